// File: rtl/pixel_pkg.sv
// Shared widths, types and keep-mask helper for the pixel packer.
// Pure declarations; no timing or flow-control behaviour.
package pixel_pkg;

  localparam int PIX_W            = 8;
  localparam int WORD_W           = 32;
  localparam int BYTES_PER_WORD   = 4;
  localparam int FRAME_PIXELS_DEF = 98304;
  localparam int CNT_W            = 17;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef logic [WORD_W-1:0]         word_t;
  typedef logic [BYTES_PER_WORD-1:0] keep_t;

  typedef struct packed {
    word_t data;
    keep_t keep;
    logic  last;
  } out_word_t;

  // Keep mask for a word whose last written byte sits at index last_idx (0 = [31:24]).
  function automatic keep_t keep_mask(input logic [1:0] last_idx);
    return keep_t'(4'b1111 << (2'd3 - last_idx));
  endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out bundle; slave is the packer, master is the surrounding pipeline.
// No state; frame_done rides along with the output stream.
interface pixel_packer_if;
  import pixel_pkg::*;

  logic  in_valid;
  pix_t  in_data;
  logic  in_ready;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  keep_t out_keep;
  logic  out_last;
  logic  frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, frame_done
  );

endinterface

// File: rtl/pixel_packer.sv
// Packs 8-bit pixels MSB-first into 32-bit words, closing early on the frame's last pixel.
// Latency 1 cycle; in_ready drops combinationally only while a held word is stalled.
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pixel_packer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  word_t            acc_q, acc_d;
  out_word_t        out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;

  logic  in_rdy;
  logic  in_fire;
  logic  out_fire;
  logic  last_pix;
  logic  word_done;
  word_t merged;

  assign in_rdy    = !(out_valid_q && !bus.out_ready);
  assign in_fire   = bus.in_valid && in_rdy;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_pix  = (pix_cnt_q == LAST_PIX);
  assign word_done = (byte_idx_q == 2'd3) || last_pix;
  assign merged    = acc_q | (word_t'(bus.in_data) << {2'd3 - byte_idx_q, 3'b000});

  always_comb begin
    byte_idx_d   = byte_idx_q;
    pix_cnt_d    = pix_cnt_q;
    acc_d        = acc_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    frame_done_d = out_fire && out_q.last;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_d.last  = 1'b0;
    end

    // A completing input overrides the drain above, giving back-to-back words.
    if (in_fire) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + CNT_W'(1);
      if (word_done) begin
        out_d.data  = merged;
        out_d.keep  = keep_mask(byte_idx_q);
        out_d.last  = last_pix;
        out_valid_d = 1'b1;
        acc_d       = '0;
        byte_idx_d  = 2'd0;
      end else begin
        acc_d      = merged;
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q   <= 2'd0;
      pix_cnt_q    <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_q.data;
  assign bus.out_keep   = out_q.keep;
  assign bus.out_last   = out_q.last;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Three packers (frames of 8, 6 and 103 pixels) against a queue-based reference model.
module tb_pixel_packer;

  typedef logic [36:0] ent_t;  // {data, keep, last}

  logic clk;
  logic rst;

  logic        in_valid    [3];
  logic [7:0]  in_data     [3];
  logic        out_ready   [3];
  logic        in_ready_s  [3];
  logic        out_valid_s [3];
  logic [31:0] out_data_s  [3];
  logic [3:0]  out_keep_s  [3];
  logic        out_last_s  [3];
  logic        frame_done_s[3];

  function automatic int fp_of(input int k);
    case (k)
      0:       return 8;
      1:       return 6;
      default: return 103;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pixel_packer_if bus_if ();
    assign bus_if.in_valid  = in_valid[g];
    assign bus_if.in_data   = in_data[g];
    assign bus_if.out_ready = out_ready[g];
    assign in_ready_s[g]    = bus_if.in_ready;
    assign out_valid_s[g]   = bus_if.out_valid;
    assign out_data_s[g]    = bus_if.out_data;
    assign out_keep_s[g]    = bus_if.out_keep;
    assign out_last_s[g]    = bus_if.out_last;
    assign frame_done_s[g]  = bus_if.frame_done;

    pixel_packer #(.FRAME_PIXELS(fp_of(g))) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: pixels collected into words by position, closed at 4 bytes or frame end.
  int          m_cnt [3];
  int          m_nb  [3];
  logic [31:0] m_acc [3];
  ent_t        exq   [3][$];
  ent_t        got   [3][$];
  int          fd_cnt  [3];
  int          last_cnt[3];
  logic        fd_exp  [3];
  logic        hold_q  [3];
  ent_t        hold_w  [3];
  logic        mon_en;

  task automatic model_clear(input int k);
    m_cnt[k] = 0;
    m_nb[k]  = 0;
    m_acc[k] = '0;
    exq[k].delete();
  endtask

  task automatic model_push(input int k, input logic [7:0] d);
    logic       is_last;
    logic [3:0] keep;
    is_last  = (m_cnt[k] == fp_of(k) - 1);
    m_acc[k] = m_acc[k] | (32'(d) << (8 * (3 - m_nb[k])));
    m_nb[k]  = m_nb[k] + 1;
    if (m_nb[k] == 4 || is_last) begin
      keep = 4'(((1 << m_nb[k]) - 1) << (4 - m_nb[k]));
      exq[k].push_back({m_acc[k], keep, is_last});
      m_acc[k] = '0;
      m_nb[k]  = 0;
    end
    m_cnt[k] = is_last ? 0 : m_cnt[k] + 1;
  endtask

  // Inputs change just after posedge, so the negedge view predicts the next edge exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        ent_t w;
        w = {out_data_s[k], out_keep_s[k], out_last_s[k]};
        chk("in_ready_rule", 64'(in_ready_s[k]), 64'(!(out_valid_s[k] && !out_ready[k])));
        chk("frame_done", 64'(frame_done_s[k]), 64'(fd_exp[k]));
        if (frame_done_s[k]) fd_cnt[k]++;
        if (hold_q[k]) begin
          chk("hold_valid", 64'(out_valid_s[k]), 64'd1);
          chk("hold_word", 64'(w), 64'(hold_w[k]));
        end
        hold_q[k] = out_valid_s[k] && !out_ready[k] && !rst;
        hold_w[k] = w;
        fd_exp[k] = 1'b0;
        if (rst) begin
          model_clear(k);
        end else begin
          if (out_valid_s[k] && out_ready[k]) begin
            got[k].push_back(w);
            chk("word_expected", 64'(exq[k].size() != 0), 64'd1);
            if (exq[k].size() != 0) begin
              ent_t e;
              e = exq[k].pop_front();
              chk("word", 64'(w), 64'(e));
              if (e[0]) begin
                fd_exp[k] = 1'b1;
                last_cnt[k]++;
              end
            end
          end
          if (in_valid[k] && in_ready_s[k]) model_push(k, in_data[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    logic accepted;
    accepted    = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int n = 0; n < 100 && !accepted; n++) begin
      #1;
      accepted = in_ready_s[k];
      step();
    end
    chk("send_accepted", 64'(accepted), 64'd1);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int   idx;
    int   cyc;
    logic v;
    logic r;
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
      fd_cnt[k]    = 0;
      last_cnt[k]  = 0;
      fd_exp[k]    = 1'b0;
      hold_q[k]    = 1'b0;
      hold_w[k]    = '0;
      model_clear(k);
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 64'(out_valid_s[k]), 64'd0);
      chk("rst_out_last", 64'(out_last_s[k]), 64'd0);
      chk("rst_frame_done", 64'(frame_done_s[k]), 64'd0);
      chk("rst_out_data", 64'(out_data_s[k]), 64'd0);
      chk("rst_out_keep", 64'(out_keep_s[k]), 64'd0);
      chk("rst_in_ready", 64'(in_ready_s[k]), 64'd1);
    end
    mon_en = 1'b1;
    rst    = 1'b0;
    step();

    // Eight-pixel frame, sink always ready.
    for (int i = 1; i <= 8; i++) begin
      send(0, 8'(i));
      if (i == 4) begin
        chk("lat_valid", 64'(out_valid_s[0]), 64'd1);
        chk("lat_data", 64'(out_data_s[0]), 64'h0102_0304);
      end
    end
    repeat (3) step();
    chk("f8_count", 64'(got[0].size()), 64'd2);
    if (got[0].size() == 2) begin
      chk("f8_w0", 64'(got[0][0]), 64'({32'h0102_0304, 4'hF, 1'b0}));
      chk("f8_w1", 64'(got[0][1]), 64'({32'h0506_0708, 4'hF, 1'b1}));
    end
    chk("f8_frame_done", 64'(fd_cnt[0]), 64'd1);

    // Six-pixel frame ends on a half word, then the next frame starts fresh.
    for (int i = 0; i < 6; i++) send(1, 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) send(1, 8'(8'hB0 + i));
    repeat (3) step();
    chk("f6_count", 64'(got[1].size()), 64'd3);
    if (got[1].size() == 3) begin
      chk("f6_w0", 64'(got[1][0]), 64'({32'hA0A1_A2A3, 4'hF, 1'b0}));
      chk("f6_w1", 64'(got[1][1]), 64'({32'hA4A5_0000, 4'hC, 1'b1}));
      chk("f6_next", 64'(got[1][2]), 64'({32'hB0B1_B2B3, 4'hF, 1'b0}));
    end

    // Stalled sink for five cycles while a word is pending.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'(8'h21 + i));
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h25;
    for (int n = 0; n < 5; n++) begin
      chk("stall_in_ready", 64'(in_ready_s[0]), 64'd0);
      chk("stall_data", 64'(out_data_s[0]), 64'h2122_2324);
      step();
    end
    out_ready[0] = 1'b1;
    for (int i = 4; i < 8; i++) send(0, 8'(8'h21 + i));
    repeat (3) step();
    chk("stall_count", 64'(got[0].size()), 64'd4);
    if (got[0].size() == 4) begin
      chk("stall_w0", 64'(got[0][2]), 64'({32'h2122_2324, 4'hF, 1'b0}));
      chk("stall_w1", 64'(got[0][3]), 64'({32'h2526_2728, 4'hF, 1'b1}));
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 3; i++) send(0, 8'(8'h31 + i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid_s[0]), 64'd0);
    chk("mid_rst_data", 64'(out_data_s[0]), 64'd0);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h11 + i));
    repeat (2) step();
    chk("mid_rst_count", 64'(got[0].size()), 64'd5);
    if (got[0].size() == 5)
      chk("mid_rst_word", 64'(got[0][4]), 64'({32'h1112_1314, 4'hF, 1'b0}));

    // Random valid/ready over four 103-pixel frames of a cyclic ramp.
    idx = 0;
    cyc = 0;
    while (idx < 4 * 103 && cyc < 20000) begin
      v = ($urandom % 10) < 7;
      r = ($urandom % 10) < 6;
      in_valid[2]  = v;
      in_data[2]   = 8'(idx);
      out_ready[2] = r;
      #1;
      if (v && in_ready_s[2]) idx++;
      step();
      cyc++;
    end
    chk("rand_all_sent", 64'(idx), 64'(4 * 103));
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    repeat (10) step();
    chk("rand_words", 64'(got[2].size()), 64'd104);
    chk("rand_lasts", 64'(last_cnt[2]), 64'd4);
    chk("rand_frame_done", 64'(fd_cnt[2]), 64'd4);
    for (int k = 0; k < 3; k++) chk("drained", 64'(exq[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
